// File: rtl/riscv_rf_arb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// The write-port struct is sized by the package widths; the arbiter's
// ADDR_WIDTH/DATA_WIDTH parameters default to these same values.
package riscv_rf_arb_pkg;

  localparam int RF_ADDR_W = 6;
  localparam int RF_DATA_W = 32;
  localparam int NUM_REGS  = 2 ** RF_ADDR_W;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
    logic                 we;
  } rf_wport_t;

  // Round-robin pointer after a grant: one past the last granted requester.
  function automatic int next_rr_ptr(input int last, input int num_req);
    return (last + 1 >= num_req) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// A reserve and a clear to the same register in one cycle leave it busy,
// since the reserving instruction's write is still outstanding.
module riscv_rf_scoreboard
  import riscv_rf_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reserve,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic                  clr_a,
  input  logic [ADDR_WIDTH-1:0] clr_a_addr,
  input  logic                  clr_b,
  input  logic [ADDR_WIDTH-1:0] clr_b_addr,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  input  logic [ADDR_WIDTH-1:0] raddr_c,
  output logic [2:0]            hazard
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clears from the write ports first, then reserve so it takes priority.
  always_comb begin
    busy_next = busy;
    if (clr_a) busy_next[clr_a_addr] = 1'b0;
    if (clr_b) busy_next[clr_b_addr] = 1'b0;
    if (reserve && (reserve_addr != '0)) busy_next[reserve_addr] = 1'b1;
  end

  // Busy array register; reset drops all reservations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign hazard = {busy[raddr_c], busy[raddr_b], busy[raddr_a]};

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Write-back arbiter: grants up to two requesters per cycle onto register
// file write ports A/B in round-robin order, never two writes to one register.
// Optional feature macro: RF_ARB_SCOREBOARD_EN enables the pending-write
// scoreboard driving hazard_o; otherwise hazard_o is tied low.
module riscv_rf_wb_arbiter
  import riscv_rf_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [ADDR_WIDTH-1:0]               waddr_a_o,
  output logic [DATA_WIDTH-1:0]               wdata_a_o,
  output logic                                we_a_o,
  output logic [ADDR_WIDTH-1:0]               waddr_b_o,
  output logic [DATA_WIDTH-1:0]               wdata_b_o,
  output logic                                we_b_o,
  input  logic                                reserve_i,
  input  logic [ADDR_WIDTH-1:0]               reserve_addr_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_a_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_b_i,
  input  logic [ADDR_WIDTH-1:0]               raddr_c_i,
  output logic [2:0]                          hazard_o
);

  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W:0]   scan;
  logic             found_a, found_b;
  logic [PTR_W-1:0] idx_a, idx_b, idx_last;
  rf_wport_t        port_a, port_b;

  // Scan from rr_ptr with wrap; first valid takes A, next valid with a
  // different destination takes B.
  always_comb begin
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
      if (req_valid_i[scan[PTR_W-1:0]]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = scan[PTR_W-1:0];
        end else if (!found_b && (req_addr_i[scan[PTR_W-1:0]] != req_addr_i[idx_a])) begin
          found_b = 1'b1;
          idx_b   = scan[PTR_W-1:0];
        end
      end
    end
  end

  // Grant vector built only from the scan result.
  always_comb begin
    req_ready_o = '0;
    if (found_a) req_ready_o[idx_a] = 1'b1;
    if (found_b) req_ready_o[idx_b] = 1'b1;
  end

  assign idx_last = found_b ? idx_b : idx_a;

  // Round-robin pointer moves past the last granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rr_ptr <= '0;
    else if (found_a) rr_ptr <= PTR_W'(next_rr_ptr(int'(idx_last), NUM_REQ));
  end

  // Register granted writes; writes to register 0 consume a slot but never enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_a <= '0;
      port_b <= '0;
    end else begin
      port_a.we <= found_a && (req_addr_i[idx_a] != '0);
      port_b.we <= found_b && (req_addr_i[idx_b] != '0);
      if (found_a) begin
        port_a.addr <= req_addr_i[idx_a];
        port_a.data <= req_data_i[idx_a];
      end
      if (found_b) begin
        port_b.addr <= req_addr_i[idx_b];
        port_b.data <= req_data_i[idx_b];
      end
    end
  end

  assign waddr_a_o = port_a.addr;
  assign wdata_a_o = port_a.data;
  assign we_a_o    = port_a.we;
  assign waddr_b_o = port_b.addr;
  assign wdata_b_o = port_b.data;
  assign we_b_o    = port_b.we;

`ifdef RF_ARB_SCOREBOARD_EN
  // Clears use the registered write ports so hazard drops as the RF captures.
  riscv_rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .reserve      (reserve_i),
    .reserve_addr (reserve_addr_i),
    .clr_a        (port_a.we),
    .clr_a_addr   (port_a.addr),
    .clr_b        (port_b.we),
    .clr_b_addr   (port_b.addr),
    .raddr_a      (raddr_a_i),
    .raddr_b      (raddr_b_i),
    .raddr_c      (raddr_c_i),
    .hazard       (hazard_o)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{reserve_i, reserve_addr_i, raddr_a_i, raddr_b_i, raddr_c_i};
  assign hazard_o  = 3'b000;
`endif

endmodule

// File: doc/riscv_rf_wb_arbiter.md
# riscv_rf_wb_arbiter

Write-back arbiter and scoreboard in front of the core register file. It collects write-back requests from NUM_REQ producers (ALU, LSU, multicycle MUL/DIV, FPU) and schedules at most two of them per cycle onto the register file's write ports A and B. Grants are round-robin so no producer starves. An optional pending-write scoreboard flags read-after-write hazards for the three register-file read addresses, so the decode stage can stall.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- ADDR_WIDTH, 6, register address width (bit 5 selects the FP bank)
- DATA_WIDTH, 32, write data width

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester write-back valid
- req_addr_i  in  NUM_REQ x ADDR_WIDTH  destination register per requester
- req_data_i  in  NUM_REQ x DATA_WIDTH  write data per requester
- req_ready_o  out  NUM_REQ  grant; a transfer occurs when valid and ready are both high
- waddr_a_o / wdata_a_o / we_a_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port A
- waddr_b_o / wdata_b_o / we_b_o  out  ADDR_WIDTH / DATA_WIDTH / 1  register file write port B
- reserve_i  in  1  decode has issued an instruction that will write reserve_addr_i
- reserve_addr_i  in  ADDR_WIDTH  destination register being reserved
- raddr_a_i, raddr_b_i, raddr_c_i  in  ADDR_WIDTH each  decode read addresses
- hazard_o  out  3  bit k high: read address k has a pending write

## Operation
- Scan order:
  - Requesters are scanned starting at rr_ptr and wrapping modulo NUM_REQ.
  - The first valid requester found gets port A; the next valid one gets port B.
- Same-destination conflict:
  - If the second candidate targets the same req_addr_i as the first, it is not granted this cycle; the scan continues to the next candidate.
  - Two writes to one register are never issued in the same cycle.
- Register 0:
  - A request to address 0 is granted and consumes its slot.
  - The write is suppressed: we_x_o stays 0 for that slot.
- Pointer update:
  - After any grant, rr_ptr advances to (index of last granted requester + 1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- req_ready_o is combinational from req_valid_i, req_addr_i and rr_ptr. It never depends on any other ready.
- Scoreboard: one busy bit per register (2**ADDR_WIDTH bits).
  - Set: reserve_i sets busy[reserve_addr_i].
  - Clear: each granted non-zero write clears busy[addr].
  - busy[0] is never set.
  - If a reserve and a clear hit the same address in the same cycle, the reserve wins and the bit stays set.
- hazard_o[k] = busy[raddr_k_i]; combinational.

## Timing
- Grant to write port: 1 cycle. Granted data, address and enable are registered and appear on port A/B in the cycle after the handshake.
- The register file captures the write at the end of that cycle.
- Scoreboard clear takes effect at the same edge the register file captures the write. The reader sees hazard_o low in the cycle after the write cycle, when the register file data is already valid.
- Reserve takes effect one edge after reserve_i: hazard_o is high from the next cycle.
- Reset values:
  - we_a_o, we_b_o = 0; waddr_x_o, wdata_x_o = 0
  - rr_ptr = 0
  - all busy bits = 0, hazard_o = 0
  - req_ready_o follows its combinational rule
- Reset mid-operation:
  - In-flight registered writes are discarded.
  - All reservations are dropped.

## Configuration
- RF_ARB_SCOREBOARD_EN defined: the busy array, reserve logic and hazard_o are implemented as described above.
- RF_ARB_SCOREBOARD_EN not defined:
  - The busy array is absent and hazard_o is tied to 0.
  - reserve_i and reserve_addr_i are ignored.
  - Arbitration is unchanged.

## Structure
- Shared package riscv_rf_arb_pkg holds:
  - localparam NUM_REGS = 2**ADDR_WIDTH
  - the write-port struct typedef rf_wport_t {addr, data, we}
  - the function next_rr_ptr()
- One sub-module: riscv_rf_scoreboard (busy array, set/clear/priority, hazard lookup). It is instantiated only under RF_ARB_SCOREBOARD_EN.

## Test plan
- Single requester: req0 valid, addr 5, data 0xDEADBEEF → ready0=1; next cycle we_a_o=1, waddr_a_o=5, wdata_a_o=0xDEADBEEF, we_b_o=0.
- Three requesters valid to addrs 3/4/7 with rr_ptr=0 → req0 on A, req1 on B; next cycle rr_ptr=2 and req2 gets port A.
- req0 and req1 both valid to addr 9, req2 to addr 10 → req0 on A, req2 on B, req1 held; req1 is granted the following cycle.
- Write to addr 0 → ready high, we_a_o stays 0, busy unchanged.
- Scoreboard:
  - reserve addr 12 → hazard_o[0]=1 while raddr_a_i=12.
  - Write-back to 12 → hazard clears the cycle after the write cycle.
  - Reserve and write-back to 12 in the same cycle → hazard stays 1.
- rst_n asserted while we_a_o=1 and busy[12]=1 → outputs 0 and hazard_o=0 immediately; rr_ptr=0 after release.
